// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pipe_pkg
// Purpose  : Shared types and default widths for the MIPS pipeline registers.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int CTRL_W         = 3;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
    } ex_mem_ctrl_t;

endpackage : mips_pipe_pkg
`default_nettype wire

// File: rtl/ex_mem_stage_pipe_slot.sv
`default_nettype none
// ============================================================================
// Module   : pipe_slot
// Purpose  : Payload register with clear (highest priority), load and hold.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Purpose  : EX->MEM pipeline register with valid/ready, stall and flush.
//            Define EX_MEM_SKID_EN for a two-entry skid-buffered variant.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_stage
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_e,
    output logic                  ready_e,
    input  logic                  reg_write_e,
    input  logic                  mem_to_reg_e,
    input  logic                  mem_write_e,
    input  logic [DATA_W-1:0]     alu_out_e,
    input  logic [DATA_W-1:0]     write_data_e,
    input  logic [REG_ADDR_W-1:0] write_reg_e,
    input  logic                  stall_m,
    input  logic                  flush_m,
    output logic                  valid_m,
    input  logic                  ready_m,
    output logic                  reg_write_m,
    output logic                  mem_to_reg_m,
    output logic                  mem_write_m,
    output logic [DATA_W-1:0]     alu_out_m,
    output logic [DATA_W-1:0]     write_data_m,
    output logic [REG_ADDR_W-1:0] write_reg_m
);

    localparam int c_PAY_W = CTRL_W + 2 * DATA_W + REG_ADDR_W;

    ex_mem_ctrl_t       w_ctrl_e;
    ex_mem_ctrl_t       w_ctrl_m;
    logic [c_PAY_W-1:0] w_pay_e;
    logic [c_PAY_W-1:0] w_pay_m;
    logic               w_rdy;
    logic               w_up;
    logic               w_dn;
    logic               r_valid_m;

    assign w_ctrl_e.reg_write  = reg_write_e;
    assign w_ctrl_e.mem_to_reg = mem_to_reg_e;
    assign w_ctrl_e.mem_write  = mem_write_e;
    assign w_pay_e = {w_ctrl_e, alu_out_e, write_data_e, write_reg_e};

    assign w_rdy = ready_m & ~stall_m;
    assign w_up  = valid_e & ready_e & ~flush_m;
    assign w_dn  = r_valid_m & w_rdy;

`ifdef EX_MEM_SKID_EN
    logic               r_skid_valid;
    logic               w_out_free;
    logic               w_out_load;
    logic               w_skid_load;
    logic [c_PAY_W-1:0] w_out_d;
    logic [c_PAY_W-1:0] w_skid_q;

    // Depends only on stored occupancy and the hazard stall, never on ready_m.
    assign ready_e     = ~r_skid_valid & ~stall_m;
    assign w_out_free  = ~r_valid_m | w_dn;
    assign w_out_load  = r_skid_valid ? w_dn : (w_up & w_out_free);
    assign w_out_d     = r_skid_valid ? w_skid_q : w_pay_e;
    assign w_skid_load = ~r_skid_valid & w_up & ~w_out_free;

    always_ff @(posedge clk) begin
        if (reset || flush_m) begin
            r_valid_m    <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_out_load) begin
                r_valid_m <= 1'b1;
            end else if (w_dn) begin
                r_valid_m <= 1'b0;
            end
            if (w_skid_load) begin
                r_skid_valid <= 1'b1;
            end else if (r_skid_valid && w_dn) begin
                r_skid_valid <= 1'b0;
            end
        end
    end

    pipe_slot #(.W(c_PAY_W)) u_skid_slot (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (flush_m),
        .i_d     (w_pay_e),
        .o_q     (w_skid_q)
    );

    pipe_slot #(.W(c_PAY_W)) u_out_slot (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_out_load),
        .i_clear (flush_m),
        .i_d     (w_out_d),
        .o_q     (w_pay_m)
    );
`else
    assign ready_e = (~r_valid_m | w_rdy) & ~stall_m;

    always_ff @(posedge clk) begin
        if (reset || flush_m) begin
            r_valid_m <= 1'b0;
        end else if (w_up) begin
            r_valid_m <= 1'b1;
        end else if (w_dn) begin
            r_valid_m <= 1'b0;
        end
    end

    pipe_slot #(.W(c_PAY_W)) u_out_slot (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_up),
        .i_clear (flush_m),
        .i_d     (w_pay_e),
        .o_q     (w_pay_m)
    );
`endif

    assign {w_ctrl_m, alu_out_m, write_data_m, write_reg_m} = w_pay_m;

    // A bubble must never write the register file or memory.
    assign valid_m      = r_valid_m;
    assign reg_write_m  = w_ctrl_m.reg_write  & r_valid_m;
    assign mem_to_reg_m = w_ctrl_m.mem_to_reg & r_valid_m;
    assign mem_write_m  = w_ctrl_m.mem_write  & r_valid_m;

endmodule : ex_mem_stage
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage
// Purpose  : Self-checking bench for ex_mem_stage (queue model + directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;
    import mips_pipe_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int PW = 3 + 2 * DW + AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          valid_e = 1'b0;
    logic          ready_e;
    logic          reg_write_e = 1'b0;
    logic          mem_to_reg_e = 1'b0;
    logic          mem_write_e = 1'b0;
    logic [DW-1:0] alu_out_e = '0;
    logic [DW-1:0] write_data_e = '0;
    logic [AW-1:0] write_reg_e = '0;
    logic          stall_m = 1'b0;
    logic          flush_m = 1'b0;
    logic          valid_m;
    logic          ready_m = 1'b1;
    logic          reg_write_m;
    logic          mem_to_reg_m;
    logic          mem_write_m;
    logic [DW-1:0] alu_out_m;
    logic [DW-1:0] write_data_m;
    logic [AW-1:0] write_reg_m;

    always #5 clk = ~clk;

    ex_mem_stage #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_e      (valid_e),
        .ready_e      (ready_e),
        .reg_write_e  (reg_write_e),
        .mem_to_reg_e (mem_to_reg_e),
        .mem_write_e  (mem_write_e),
        .alu_out_e    (alu_out_e),
        .write_data_e (write_data_e),
        .write_reg_e  (write_reg_e),
        .stall_m      (stall_m),
        .flush_m      (flush_m),
        .valid_m      (valid_m),
        .ready_m      (ready_m),
        .reg_write_m  (reg_write_m),
        .mem_to_reg_m (mem_to_reg_m),
        .mem_write_m  (mem_write_m),
        .alu_out_m    (alu_out_m),
        .write_data_m (write_data_m),
        .write_reg_m  (write_reg_m)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the stage is a FIFO of at most 1 (base) or 2 (skid) beats; head is MEM.
    logic [PW-1:0] q[$];
    logic [PW-1:0] last = '0;
    bit            chk_en = 1'b0;

    function automatic bit exp_ready();
`ifdef EX_MEM_SKID_EN
        return (q.size() < 2) && !stall_m;
`else
        return (q.size() == 0 || (ready_m && !stall_m)) && !stall_m;
`endif
    endfunction

    always @(posedge clk) begin
        bit up;
        bit dn;
        if (reset) begin
            q.delete();
            last   = '0;
            chk_en = 1'b1;
        end else if (flush_m) begin
            q.delete();
            last = '0;
        end else begin
            up = valid_e && exp_ready();
            dn = (q.size() > 0) && ready_m && !stall_m;
            if (dn) void'(q.pop_front());
            if (up) q.push_back({reg_write_e, mem_to_reg_e, mem_write_e,
                                 alu_out_e, write_data_e, write_reg_e});
            if (q.size() > 0) last = q[0];
        end
    end

    always @(negedge clk) begin
        logic [PW-1:0] e;
        bit            v;
        if (chk_en) begin
            v = (q.size() > 0);
            e = last;
            check("valid_m",      valid_m,      v);
            check("ready_e",      ready_e,      exp_ready());
            check("reg_write_m",  reg_write_m,  e[PW-1] & v);
            check("mem_to_reg_m", mem_to_reg_m, e[PW-2] & v);
            check("mem_write_m",  mem_write_m,  e[PW-3] & v);
            check("alu_out_m",    alu_out_m,    e[PW-4 -: DW]);
            check("write_data_m", write_data_m, e[DW+AW-1 -: DW]);
            check("write_reg_m",  write_reg_m,  e[AW-1:0]);
        end
    end

    task automatic drive(input bit v, input bit rw, input bit mtr, input bit mw,
                         input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                         input logic [AW-1:0] wr);
        valid_e      = v;
        reg_write_e  = rw;
        mem_to_reg_e = mtr;
        mem_write_e  = mw;
        alu_out_e    = alu;
        write_data_e = wd;
        write_reg_e  = wr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h11, 5'd5);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    initial begin
        // Reset while a beat is being offered
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 5'd31);
        tick(); tick();
        check("rst valid_m",     valid_m,      1'b0);
        check("rst alu_out_m",   alu_out_m,    32'h0);
        check("rst write_data",  write_data_m, 32'h0);
        check("rst reg_write_m", reg_write_m,  1'b0);
        check("rst ready_e",     ready_e,      1'b1);
        reset = 1'b0;

        // Streaming A then B
        send_a();
        tick();
        check("stream A valid", valid_m,     1'b1);
        check("stream A alu",   alu_out_m,   32'h10);
        check("stream A reg",   write_reg_m, 5'd5);
        check("stream A rw",    reg_write_m, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h21, 5'd6);
        tick();
        check("stream B alu",   alu_out_m,   32'h20);
        check("stream B reg",   write_reg_m, 5'd6);
        check("stream B rw",    reg_write_m, 1'b0);
        idle();
        tick();
        check("stream drained", valid_m, 1'b0);

        // Stall with A held, B offered
        send_a();
        tick();
        stall_m = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h21, 5'd6);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall ready_e", ready_e,   1'b0);
            check("stall alu",     alu_out_m, 32'h10);
            check("stall valid",   valid_m,   1'b1);
        end
        stall_m = 1'b0;
        tick();
        check("post-stall B alu", alu_out_m, 32'h20);
        idle();
        tick();

        // Flush with A stored and B (MemWrite) offered
        ready_m = 1'b0;
        send_a();
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 32'h21, 5'd6);
        flush_m = 1'b1;
        tick();
        check("flush valid",     valid_m,     1'b0);
        check("flush mem_write", mem_write_m, 1'b0);
        check("flush alu",       alu_out_m,   32'h0);
        flush_m = 1'b0;
        idle();
        ready_m = 1'b1;
        tick(); tick();
        check("flush B absent", valid_m, 1'b0);

        // Backpressure: A held, B arrives
        ready_m = 1'b0;
        send_a();
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h21, 5'd6);
`ifdef EX_MEM_SKID_EN
        tick();
        check("bp A held",      alu_out_m, 32'h10);
        check("bp skid full",   ready_e,   1'b0);
        idle();
        ready_m = 1'b1;
        tick();
        check("bp B second",    alu_out_m, 32'h20);
        check("bp B valid",     valid_m,   1'b1);
        tick();
        check("bp drained",     valid_m,   1'b0);
`else
        check("bp ready_e low", ready_e, 1'b0);
        tick();
        check("bp A held",      alu_out_m, 32'h10);
        ready_m = 1'b1;
        tick();
        check("bp B second",    alu_out_m, 32'h20);
        idle();
        tick();
        check("bp drained",     valid_m, 1'b0);
`endif

        // Bubbles carrying write controls
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h55, 32'h66, 5'd7);
        for (int i = 0; i < 4; i++) begin
            ready_m = i[0];
            tick();
            check("bubble rw", reg_write_m, 1'b0);
            check("bubble mw", mem_write_m, 1'b0);
        end
        ready_m = 1'b1;

        // Reset mid-operation
        ready_m = 1'b0;
        send_a();
        tick();
        check("midrst loaded", valid_m, 1'b1);
        reset = 1'b1;
        idle();
        tick();
        check("midrst valid", valid_m,   1'b0);
        check("midrst alu",   alu_out_m, 32'h0);
        reset = 1'b0;
        ready_m = 1'b1;

        // Mixed traffic checked by the model
        for (int i = 0; i < 80; i++) begin
            drive(1'($urandom_range(0, 1)), 1'(i), 1'(i >> 1), 1'(i >> 2),
                  32'h1000 + 32'(i), 32'hA000 + 32'(i), 5'(i));
            ready_m = ($urandom_range(0, 3) != 0);
            stall_m = ($urandom_range(0, 7) == 0);
            flush_m = ($urandom_range(0, 15) == 0);
            tick();
        end
        idle();
        stall_m = 1'b0;
        flush_m = 1'b0;
        ready_m = 1'b1;
        tick(); tick(); tick();
        check("final drained", valid_m, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ex_mem_stage
`default_nettype wire

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Parametrised EX->MEM inter-stage register for the pipelined MIPS core; successor to the fixed 32-bit, always-loading EX/MEM latch.
- Adds a valid/ready handshake, hazard-unit stall and flush, and control-bit qualification by valid.
- An optional skid buffer gives full throughput with a registered upstream ready.
- Sits between the ALU stage and data memory; its outputs feed the MEM stage and the forwarding unit.

Parameters:
- DATA_W, 32, width of the ALU result and store-data fields.
- REG_ADDR_W, 5, width of the destination register index.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- valid_e  in  1  EX beat present.
- ready_e  out  1  stage can accept a beat this cycle.
- reg_write_e  in  1  RegWrite control.
- mem_to_reg_e  in  1  MemtoReg control.
- mem_write_e  in  1  MemWrite control.
- alu_out_e  in  DATA_W  ALU result.
- write_data_e  in  DATA_W  store data.
- write_reg_e  in  REG_ADDR_W  destination register.
- stall_m  in  1  hazard unit: hold MEM contents, accept nothing.
- flush_m  in  1  hazard unit: squash stored and incoming beats.
- valid_m  out  1  MEM beat present.
- ready_m  in  1  MEM consumes the beat.
- reg_write_m, mem_to_reg_m, mem_write_m  out  1 each  controls, forced 0 when valid_m=0.
- alu_out_m  out  DATA_W  registered ALU result.
- write_data_m  out  DATA_W  registered store data.
- write_reg_m  out  REG_ADDR_W  registered destination.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: valid_m=0; all data fields and controls 0. With SKID_EN, the skid buffer is empty and ready_e=1.
- Reset mid-operation discards every stored beat on the next edge.
- Effective downstream ready: rdy = ready_m & ~stall_m.
- Transfers:
  - Upstream transfer occurs when valid_e & ready_e & ~flush_m.
  - Downstream transfer occurs when valid_m & rdy.
- Latency: 1 cycle from upstream transfer to valid_m (both builds).
- Base build: ready_e = (~valid_m | rdy) & ~stall_m, combinational.
  - On upstream transfer, all fields load and valid_m<=1.
  - Else, if a downstream transfer occurs, valid_m<=0.
  - Else, hold.
- Hold rule: fields never change while valid_m=1 and rdy=0. No overwrite and no drop.
- Flush priority: flush_m > reset-free load/hold.
  - Next edge sets valid_m<=0 and zeroes all fields; the skid buffer empties.
  - A beat offered in the flush cycle is discarded.
  - ready_e still follows its rule, so upstream treats the beat as consumed.
- Flush and stall asserted together: flush wins.
- Stall: ready_e=0. The output register holds and valid_m holds; MEM sees valid_m but must not consume (rdy=0).
- Control qualification: *_m controls = stored bit & valid_m. A bubble never writes the register file or memory.
- Widths: straight register copies, no arithmetic, no sign extension.

Optional Feature:
- Macro: EX_MEM_SKID_EN.
- Defined: two-entry stage (output register + skid register).
  - ready_e is registered and equals ~skid_full & ~stall_m; there is no combinational path from ready_m to ready_e.
  - If the output is occupied and not drained when a beat arrives, the beat goes to the skid register.
  - When the output drains, the skid entry moves to the output with priority over new input; ordering is preserved.
  - Sustains 1 beat/cycle under continuous ready_m.
  - Flush empties both entries.
- Undefined: single-entry behaviour as above; the skid logic is absent.

Decomposition:
- Package mips_pipe_pkg:
  - ex_mem_ctrl_t packed struct {reg_write, mem_to_reg, mem_write}.
  - Default widths DATA_W_DEF=32 and REG_ADDR_W_DEF=5.
  - CTRL_W=3.
- One natural sub-module, pipe_slot: a payload register with load/clear/hold, instantiated once in the base build and twice under EX_MEM_SKID_EN.

Test Plan:
- Reset asserted 2 cycles while valid_e=1 with alu_out_e=0xDEADBEEF -> valid_m=0, all outputs 0, reg_write_m=0; with skid, ready_e=1.
- Streaming:
  - Stimulus: ready_m=1; beats A (alu 0x10, reg 5, RegWrite=1) and B (alu 0x20, reg 6) on consecutive cycles.
  - Response: A appears on valid_m the next cycle, then B; no gaps.
- Stall:
  - Stimulus: stall_m=1 for 3 cycles with A held in MEM.
  - Response: ready_e=0; alu_out_m=0x10 and valid_m=1 constant; offered beat B not accepted until stall drops; B then follows A.
- Flush:
  - Stimulus: flush_m=1 with A stored and B offered (MemWrite=1).
  - Response: next cycle valid_m=0, mem_write_m=0, alu_out_m=0; B never appears.
- Backpressure (EX_MEM_SKID_EN):
  - Stimulus: ready_m=0 while A and B arrive.
  - Response: A held at output; B in skid; ready_e=0 next cycle; after ready_m=1, order is A then B and no beat is lost.
- Bubble qualification:
  - Stimulus: valid_e=0 with reg_write_e=1, mem_write_e=1.
  - Response: reg_write_m=0 and mem_write_m=0 every cycle.
